// File: rtl/id_ex_alu_issue.sv
// ID/EX issue register for the RV32I execute ALU: decodes the ID instruction into
// an ALU function and operand pair, then registers them with stall/flush control.
module id_ex_alu_issue (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [31:0] csr_rdata,
    input  logic        stall,
    input  logic        flush,
    output logic [31:0] op1,
    output logic [31:0] op2,
    output logic [3:0]  ALU_func,
    output logic [4:0]  rd,
    output logic        reg_write,
    output logic        valid_out,
    output logic        illegal
);

    localparam logic [3:0] FN_ADD  = 4'd0;
    localparam logic [3:0] FN_SUB  = 4'd1;
    localparam logic [3:0] FN_SLL  = 4'd2;
    localparam logic [3:0] FN_SLT  = 4'd3;
    localparam logic [3:0] FN_SLTU = 4'd4;
    localparam logic [3:0] FN_XOR  = 4'd5;
    localparam logic [3:0] FN_SRL  = 4'd6;
    localparam logic [3:0] FN_SRA  = 4'd7;
    localparam logic [3:0] FN_OR   = 4'd8;
    localparam logic [3:0] FN_AND  = 4'd9;
    localparam logic [3:0] FN_LUI  = 4'd10;
    localparam logic [3:0] FN_OP1  = 4'd11;
    localparam logic [3:0] FN_NAND = 4'd12;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_u;
    logic [3:0]  base_func;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_u  = {instr[31:12], 12'b0};

    // Shared funct3 mapping for OP and OP-IMM; the funct7 variants are patched in later.
    always_comb begin
        base_func = FN_ADD;
        case (funct3)
            3'd0: base_func = FN_ADD;
            3'd1: base_func = FN_SLL;
            3'd2: base_func = FN_SLT;
            3'd3: base_func = FN_SLTU;
            3'd4: base_func = FN_XOR;
            3'd5: base_func = FN_SRL;
            3'd6: base_func = FN_OR;
            3'd7: base_func = FN_AND;
            default: base_func = FN_ADD;
        endcase
    end

    logic [31:0] dec_op1;
    logic [31:0] dec_op2;
    logic [3:0]  dec_func;
    logic        dec_write;
    logic        dec_illegal;

    always_comb begin
        dec_op1     = 32'd0;
        dec_op2     = 32'd0;
        dec_func    = FN_ADD;
        dec_write   = 1'b0;
        dec_illegal = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec_op1   = rs1_data;
                dec_op2   = rs2_data;
                dec_write = 1'b1;
                if (funct7 == 7'b0000000)
                    dec_func = base_func;
                else if (funct7 == 7'b0100000 && funct3 == 3'd0)
                    dec_func = FN_SUB;
                else if (funct7 == 7'b0100000 && funct3 == 3'd5)
                    dec_func = FN_SRA;
                else
                    dec_illegal = 1'b1;
            end
            OPC_OP_IMM: begin
                dec_op1   = rs1_data;
                dec_op2   = imm_i;
                dec_func  = base_func;
                dec_write = 1'b1;
                // Only the shifts reuse the upper immediate bits as funct7.
                if (funct3 == 3'd1 || funct3 == 3'd5) begin
                    dec_op2 = {27'd0, instr[24:20]};
                    if (funct7 == 7'b0100000 && funct3 == 3'd5)
                        dec_func = FN_SRA;
                    else if (funct7 != 7'b0000000)
                        dec_illegal = 1'b1;
                end
            end
            OPC_LUI: begin
                dec_func  = FN_LUI;
                dec_op2   = imm_u;
                dec_write = 1'b1;
            end
            OPC_AUIPC: begin
                dec_op1   = pc;
                dec_op2   = imm_u;
                dec_write = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
                dec_op1   = pc;
                dec_op2   = 32'd4;
                dec_write = 1'b1;
            end
            OPC_LOAD: begin
                dec_op1   = rs1_data;
                dec_op2   = imm_i;
                dec_write = 1'b1;
            end
            OPC_STORE: begin
                dec_op1 = rs1_data;
                dec_op2 = imm_s;
            end
            OPC_BRANCH: begin
                dec_func = FN_SUB;
                dec_op1  = rs1_data;
                dec_op2  = rs2_data;
                if (funct3 == 3'd2 || funct3 == 3'd3)
                    dec_illegal = 1'b1;
            end
            OPC_SYSTEM: begin
                dec_op2   = csr_rdata;
                dec_op1   = funct3[2] ? {27'd0, instr[19:15]} : rs1_data;
                dec_write = 1'b1;
                case (funct3[1:0])
                    2'd1:    dec_func = FN_OP1;
                    2'd2:    dec_func = FN_OR;
                    2'd3:    dec_func = FN_NAND;
                    default: dec_illegal = 1'b1;
                endcase
            end
            default: dec_illegal = 1'b1;
        endcase
        if (dec_illegal) begin
            dec_op1   = 32'd0;
            dec_op2   = 32'd0;
            dec_func  = FN_ADD;
            dec_write = 1'b0;
        end
    end

    // Flush beats stall; an empty ID slot loads the same bubble as a flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op1       <= 32'd0;
            op2       <= 32'd0;
            ALU_func  <= FN_ADD;
            rd        <= 5'd0;
            reg_write <= 1'b0;
            valid_out <= 1'b0;
            illegal   <= 1'b0;
        end else if (flush || (!stall && !valid_in)) begin
            op1       <= 32'd0;
            op2       <= 32'd0;
            ALU_func  <= FN_ADD;
            rd        <= 5'd0;
            reg_write <= 1'b0;
            valid_out <= 1'b0;
            illegal   <= 1'b0;
        end else if (!stall) begin
            op1       <= dec_op1;
            op2       <= dec_op2;
            ALU_func  <= dec_func;
            rd        <= instr[11:7];
            reg_write <= dec_write && (instr[11:7] != 5'd0);
            valid_out <= 1'b1;
            illegal   <= dec_illegal;
        end
    end

endmodule

// File: tb/tb_id_ex_alu_issue.sv
// Directed self-checking bench for id_ex_alu_issue: hand-encoded instructions
// with hand-computed operand, function and control expectations.
module tb_id_ex_alu_issue;

    localparam logic [3:0] E_ADD  = 4'd0;
    localparam logic [3:0] E_SUB  = 4'd1;
    localparam logic [3:0] E_SRA  = 4'd7;
    localparam logic [3:0] E_LUI  = 4'd10;
    localparam logic [3:0] E_OP1  = 4'd11;
    localparam logic [3:0] E_NAND = 4'd12;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] csr_rdata;
    logic        stall;
    logic        flush;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [3:0]  ALU_func;
    logic [4:0]  rd;
    logic        reg_write;
    logic        valid_out;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    id_ex_alu_issue dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .instr(instr), .pc(pc),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .csr_rdata(csr_rdata),
        .stall(stall), .flush(flush), .op1(op1), .op2(op2), .ALU_func(ALU_func),
        .rd(rd), .reg_write(reg_write), .valid_out(valid_out), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_all(input string name, input logic [31:0] e_op1, input logic [31:0] e_op2,
                              input logic [3:0] e_func, input logic [4:0] e_rd, input logic e_wr,
                              input logic e_valid, input logic e_ill);
        checks++;
        if ({op1, op2, ALU_func, rd, reg_write, valid_out, illegal} !==
            {e_op1, e_op2, e_func, e_rd, e_wr, e_valid, e_ill}) begin
            errors++;
            $display("[TB] FAIL %s: got op1=%h op2=%h func=%0d rd=%0d wr=%b v=%b ill=%b, want op1=%h op2=%h func=%0d rd=%0d wr=%b v=%b ill=%b",
                     name, op1, op2, ALU_func, rd, reg_write, valid_out, illegal,
                     e_op1, e_op2, e_func, e_rd, e_wr, e_valid, e_ill);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; valid_in = 1'b0; instr = 32'd0; pc = 32'd0;
        rs1_data = 32'd0; rs2_data = 32'd0; csr_rdata = 32'd0; stall = 1'b0; flush = 1'b0;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        valid_in = 1'b1; instr = {7'b0, 5'd2, 5'd1, 3'd0, 5'd9, 7'b0110011};
        rs1_data = 32'd5; rs2_data = 32'd6;
        step();
        expect_all("add_before_reset", 32'd5, 32'd6, E_ADD, 5'd9, 1'b1, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        expect_all("async_reset", 32'd0, 32'd0, E_ADD, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1; valid_in = 1'b0;
        step();
        expect_all("post_reset_1", 32'd0, 32'd0, E_ADD, 5'd0, 1'b0, 1'b0, 1'b0);
        step();
        expect_all("post_reset_2", 32'd0, 32'd0, E_ADD, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_alu_ops();
        @(negedge clk);
        valid_in = 1'b1; rs1_data = 32'd10; rs2_data = 32'd3;
        instr = {7'b0100000, 5'd2, 5'd1, 3'd0, 5'd3, 7'b0110011};
        step();
        expect_all("sub", 32'd10, 32'd3, E_SUB, 5'd3, 1'b1, 1'b1, 1'b0);
        instr = {7'b0100000, 5'd4, 5'd1, 3'd5, 5'd5, 7'b0010011};
        step();
        expect_all("srai", 32'd10, 32'd4, E_SRA, 5'd5, 1'b1, 1'b1, 1'b0);
        instr = {20'h12345, 5'd7, 7'b0010111}; pc = 32'h100;
        step();
        expect_all("auipc", 32'h100, 32'h12345000, E_ADD, 5'd7, 1'b1, 1'b1, 1'b0);
        instr = {20'h00000, 5'd1, 7'b1101111}; pc = 32'h200;
        step();
        expect_all("jal", 32'h200, 32'd4, E_ADD, 5'd1, 1'b1, 1'b1, 1'b0);
        instr = {20'hABCDE, 5'd8, 7'b0110111};
        step();
        expect_all("lui", 32'd0, 32'hABCDE000, E_LUI, 5'd8, 1'b1, 1'b1, 1'b0);
        // addi x0,x1,-1: negative immediate sign-extends, rd=0 suppresses write
        instr = {12'hFFF, 5'd1, 3'd0, 5'd0, 7'b0010011};
        step();
        expect_all("addi_x0_neg", 32'd10, 32'hFFFFFFFF, E_ADD, 5'd0, 1'b0, 1'b1, 1'b0);
        // sw x2,-8(x1): S-immediate is funct7/rd fields joined, sign-extended
        instr = {7'b1111111, 5'd2, 5'd1, 3'd2, 5'b11000, 7'b0100011};
        step();
        expect_all("store", 32'd10, 32'hFFFFFFF8, E_ADD, 5'd24, 1'b0, 1'b1, 1'b0);
        instr = {7'b0, 5'd2, 5'd1, 3'd0, 5'd8, 7'b1100011};
        step();
        expect_all("beq", 32'd10, 32'd3, E_SUB, 5'd8, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_csr();
        @(negedge clk);
        valid_in = 1'b1; rs1_data = 32'h8; csr_rdata = 32'h88;
        instr = {12'h300, 5'd6, 3'd3, 5'd4, 7'b1110011};
        step();
        expect_all("csrrc", 32'h8, 32'h88, E_NAND, 5'd4, 1'b1, 1'b1, 1'b0);
        instr = {12'h300, 5'd5, 3'd5, 5'd0, 7'b1110011};
        step();
        expect_all("csrrwi_x0", 32'd5, 32'h88, E_OP1, 5'd0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_stall_flush();
        @(negedge clk);
        valid_in = 1'b1; rs1_data = 32'd5; rs2_data = 32'd6;
        instr = {7'b0, 5'd2, 5'd1, 3'd0, 5'd9, 7'b0110011};
        step();
        expect_all("add_issue", 32'd5, 32'd6, E_ADD, 5'd9, 1'b1, 1'b1, 1'b0);
        stall = 1'b1;
        instr = {7'b0100000, 5'd2, 5'd1, 3'd0, 5'd3, 7'b0110011};
        rs1_data = 32'd77;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_all($sformatf("stall_hold_%0d", i), 32'd5, 32'd6, E_ADD, 5'd9, 1'b1, 1'b1, 1'b0);
        end
        flush = 1'b1;
        step();
        expect_all("stall_flush", 32'd0, 32'd0, E_ADD, 5'd0, 1'b0, 1'b0, 1'b0);
        flush = 1'b0; stall = 1'b0;
        step();
        expect_all("after_stall_issue", 32'd77, 32'd6, E_SUB, 5'd3, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_illegal();
        @(negedge clk);
        valid_in = 1'b1; rs1_data = 32'd1; rs2_data = 32'd2;
        instr = {7'b0100000, 5'd2, 5'd1, 3'd4, 5'd6, 7'b0110011};
        step();
        expect_all("xor_bad_f7", 32'd0, 32'd0, E_ADD, 5'd6, 1'b0, 1'b1, 1'b1);
        instr = 32'h0000_0000;
        step();
        expect_all("opcode_zero", 32'd0, 32'd0, E_ADD, 5'd0, 1'b0, 1'b1, 1'b1);
        instr = {7'b0, 5'd2, 5'd1, 3'd2, 5'd8, 7'b1100011};
        step();
        expect_all("branch_f3_2", 32'd0, 32'd0, E_ADD, 5'd8, 1'b0, 1'b1, 1'b1);
        instr = {12'h300, 5'd1, 3'd4, 5'd4, 7'b1110011};
        step();
        expect_all("system_f3_4", 32'd0, 32'd0, E_ADD, 5'd4, 1'b0, 1'b1, 1'b1);
        valid_in = 1'b0; instr = 32'h0000_0000;
        step();
        expect_all("illegal_not_valid", 32'd0, 32'd0, E_ADD, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_alu_ops();
        test_csr();
        test_stall_flush();
        test_illegal();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
